// File: rtl/mem_stage_lq_if.sv
// mem_stage_lq_if: EXE->MEM issue bundle, data-SRAM response and MEM->WB result.
// master = EXE/memory/WB side (drives requests, responses, out_ready); slave = stage.
interface mem_stage_lq_if #(
    parameter int SIDE_W = 128
);
    logic              in_valid;
    logic              in_allowin;
    logic              in_wait;
    logic              in_res_from_mem;
    logic [3:0]        in_mem_op;
    logic [31:0]       in_alu_result;
    logic [SIDE_W-1:0] in_side;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rf_wdata;
    logic [31:0]       out_alu_result;
    logic [SIDE_W-1:0] out_side;

    modport slave (
        input  in_valid, in_wait, in_res_from_mem, in_mem_op,
        input  in_alu_result, in_side,
        input  data_data_ok, data_rdata, out_ready,
        output in_allowin, out_valid, out_rf_wdata,
        output out_alu_result, out_side
    );

    modport master (
        output in_valid, in_wait, in_res_from_mem, in_mem_op,
        output in_alu_result, in_side,
        output data_data_ok, data_rdata, out_ready,
        input  in_allowin, out_valid, out_rf_wdata,
        input  out_alu_result, out_side
    );
endinterface

// File: rtl/mem_stage_lq.sv
// mem_stage_lq: in-order load queue between EXE and WB with post-flush response discard.
// Ports: clk, resetn (sync, active-low), flush, bus (slave), lq_count, discard_cnt.
module mem_stage_lq #(
    parameter  int DEPTH  = 4,
    parameter  int SIDE_W = 128,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    mem_stage_lq_if.slave bus,
    output logic [CW-1:0] lq_count,
    output logic [CW-1:0] discard_cnt
);
    logic [DEPTH-1:0]  vld_q, vld_d, wt_q, wt_d;
    logic [DEPTH-1:0]  got_q, got_d, rfm_q, rfm_d;
    logic [3:0]        op_q   [DEPTH];
    logic [3:0]        op_d   [DEPTH];
    logic [31:0]       alu_q  [DEPTH];
    logic [31:0]       alu_d  [DEPTH];
    logic [31:0]       rdat_q [DEPTH];
    logic [31:0]       rdat_d [DEPTH];
    logic [SIDE_W-1:0] side_q [DEPTH];
    logic [SIDE_W-1:0] side_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]     rsp_ptr_q, rsp_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d, disc_q, disc_d;

    logic [DEPTH-1:0] pend;
    logic [CW-1:0]    pend_cnt;
    logic             hit, drop, take, enq, deq;
    logic [PW-1:0]    hit_idx, idx;

    function automatic logic [31:0] extract(
        input logic [31:0] d,
        input logic [3:0]  op,
        input logic [1:0]  a
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (op)
            4'd0:    return {{24{b[7]}}, b};
            4'd8:    return {24'h0, b};
            4'd1:    return {{16{h[15]}}, h};
            4'd9:    return {16'h0, h};
            4'd2:    return d;
            default: return 32'h0;
        endcase
    endfunction

    assign bus.out_valid      = vld_q[head_q] & (~wt_q[head_q] | got_q[head_q]);
    assign bus.out_alu_result = alu_q[head_q];
    assign bus.out_side       = side_q[head_q];
    assign bus.out_rf_wdata   = rfm_q[head_q]
        ? extract(rdat_q[head_q], op_q[head_q], alu_q[head_q][1:0])
        : alu_q[head_q];
    assign bus.in_allowin = ~flush &
        (({1'b0, cnt_q} + {1'b0, disc_q}) < (CW+1)'(DEPTH));
    assign lq_count    = cnt_q;
    assign discard_cnt = disc_q;

    assign pend = vld_q & wt_q & ~got_q;
    assign enq  = bus.in_valid & bus.in_allowin;
    assign deq  = bus.out_valid & bus.out_ready & ~flush;
    assign drop = bus.data_data_ok & (disc_q != '0);
    assign take = bus.data_data_ok & ~drop & hit;

    // Everything between head and rsp_ptr is already resolved, so a circular
    // scan from rsp_ptr meets pending entries in program order.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = rsp_ptr_q;
        idx      = rsp_ptr_q;
        pend_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rsp_ptr_q + PW'(k);
            if (!hit && pend[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
            pend_cnt = pend_cnt + CW'(pend[k]);
        end
    end

    always_comb begin
        vld_d     = vld_q;
        wt_d      = wt_q;
        got_d     = got_q;
        rfm_d     = rfm_q;
        op_d      = op_q;
        alu_d     = alu_q;
        rdat_d    = rdat_q;
        side_d    = side_q;
        head_d    = head_q;
        tail_d    = tail_q;
        rsp_ptr_d = hit ? hit_idx : rsp_ptr_q;
        cnt_d     = cnt_q;
        disc_d    = disc_q - CW'(drop);
        if (take) begin
            got_d[hit_idx]  = 1'b1;
            rdat_d[hit_idx] = bus.data_rdata;
            rsp_ptr_d       = hit_idx + 1'b1;
        end
        if (flush) begin
            // A live-consumed response no longer counts as owed.
            vld_d     = '0;
            head_d    = '0;
            tail_d    = '0;
            rsp_ptr_d = '0;
            cnt_d     = '0;
            disc_d    = disc_q - CW'(drop) + pend_cnt - CW'(take);
        end else begin
            if (deq) begin
                vld_d[head_q] = 1'b0;
                head_d        = head_q + 1'b1;
            end
            if (enq) begin
                vld_d[tail_q]  = 1'b1;
                wt_d[tail_q]   = bus.in_wait;
                got_d[tail_q]  = 1'b0;
                rfm_d[tail_q]  = bus.in_res_from_mem;
                op_d[tail_q]   = bus.in_mem_op;
                alu_d[tail_q]  = bus.in_alu_result;
                rdat_d[tail_q] = 32'h0;
                side_d[tail_q] = bus.in_side;
                tail_d         = tail_q + 1'b1;
            end
            cnt_d = cnt_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            rsp_ptr_q <= '0;
            cnt_q     <= '0;
            disc_q    <= '0;
        end else begin
            vld_q     <= vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rsp_ptr_q <= rsp_ptr_d;
            cnt_q     <= cnt_d;
            disc_q    <= disc_d;
        end
    end

    // Payload needs no reset: it is only observed through a valid entry.
    always_ff @(posedge clk) begin
        wt_q   <= wt_d;
        got_q  <= got_d;
        rfm_q  <= rfm_d;
        op_q   <= op_d;
        alu_q  <= alu_d;
        rdat_q <= rdat_d;
        side_q <= side_d;
    end
endmodule

// File: tb/tb_mem_stage_lq.sv
// tb_mem_stage_lq: randomized stimulus against a queue-based reference model.
// Memory side modeled as an in-order queue of owed responses.
module tb_mem_stage_lq;
    localparam int DEPTH  = 4;
    localparam int SIDE_W = 128;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic [CW-1:0] lq_count;
    logic [CW-1:0] discard_cnt;

    mem_stage_lq_if #(.SIDE_W(SIDE_W)) bus ();

    mem_stage_lq #(
        .DEPTH (DEPTH),
        .SIDE_W(SIDE_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .bus        (bus),
        .lq_count   (lq_count),
        .discard_cnt(discard_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wt;
        bit         got;
        bit         rfm;
        bit [3:0]   op;
        bit [31:0]  alu;
        bit [31:0]  rd;
        bit [127:0] side;
    } ent_t;

    ent_t       mq[$];
    bit [31:0]  memq[$];
    int         disc;
    int         checks = 0;
    int         errors = 0;

    int p_flush, p_valid, p_ready, p_dok;
    bit fixed_rd;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] ref_val(input ent_t e);
        bit [31:0] v;
        int a;
        if (!e.rfm) return e.alu;
        a = int'(e.alu[1:0]);
        case (e.op)
            4'd0, 4'd8: begin
                v = (e.rd >> (8 * a)) & 32'hFF;
                if (e.op == 4'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            4'd1, 4'd9: begin
                v = (e.rd >> (16 * (a / 2))) & 32'hFFFF;
                if (e.op == 4'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            4'd2:    v = e.rd;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic idle_inputs();
        flush                = 1'b0;
        bus.in_valid         = 1'b0;
        bus.in_wait          = 1'b0;
        bus.in_res_from_mem  = 1'b0;
        bus.in_mem_op        = 4'd0;
        bus.in_alu_result    = 32'h0;
        bus.in_side          = '0;
        bus.data_data_ok     = 1'b0;
        bus.data_rdata       = 32'h0;
        bus.out_ready        = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        idle_inputs();
        mq.delete();
        memq.delete();
        disc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_lq_count", lq_count, 0);
        check("rst_discard", discard_cnt, 0);
        check("rst_allowin", bus.in_allowin, 1'b1);
    endtask

    task automatic cycle();
        bit         fl, iv, iw, irf, dok, ordy, allow, ov;
        bit [3:0]   op;
        bit [31:0]  alu, drd;
        bit [127:0] sd;
        bit [3:0]   ops[7];
        int         p;
        ops = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd5, 4'd2};
        @(negedge clk);
        fl   = $urandom_range(99) < p_flush;
        iv   = $urandom_range(99) < p_valid;
        iw   = 1'($urandom_range(1));
        irf  = iw ? ($urandom_range(7) != 0) : 1'($urandom_range(1));
        op   = ops[$urandom_range(6)];
        alu  = $urandom;
        sd   = {$urandom, $urandom, $urandom, $urandom};
        dok  = memq.size() > 0 && $urandom_range(99) < p_dok;
        drd  = dok ? memq[0] : $urandom;
        ordy = $urandom_range(99) < p_ready;

        flush               = fl;
        bus.in_valid        = iv;
        bus.in_wait         = iw;
        bus.in_res_from_mem = irf;
        bus.in_mem_op       = op;
        bus.in_alu_result   = alu;
        bus.in_side         = sd;
        bus.data_data_ok    = dok;
        bus.data_rdata      = drd;
        bus.out_ready       = ordy;
        #1;

        allow = !fl && (mq.size() + disc < DEPTH);
        ov    = mq.size() > 0 && (!mq[0].wt || mq[0].got);
        check("in_allowin", bus.in_allowin, allow);
        check("out_valid", bus.out_valid, ov);
        check("lq_count", lq_count, mq.size());
        check("discard_cnt", discard_cnt, disc);
        if (ov) begin
            check("rf_wdata", bus.out_rf_wdata, ref_val(mq[0]));
            check("alu_result", bus.out_alu_result, mq[0].alu);
            check("side", bus.out_side, mq[0].side);
        end

        @(posedge clk);
        if (dok) void'(memq.pop_front());
        if (fl) begin
            p = 0;
            foreach (mq[i]) if (mq[i].wt && !mq[i].got) p++;
            if (dok) begin
                if (disc > 0) disc--;
                else if (p > 0) p--;
            end
            disc += p;
            mq.delete();
        end else begin
            if (dok) begin
                if (disc > 0) disc--;
                else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].wt && !mq[i].got) begin
                            mq[i].got = 1'b1;
                            mq[i].rd  = drd;
                            break;
                        end
                    end
                end
            end
            if (ov && ordy) void'(mq.pop_front());
            if (iv && allow) begin
                mq.push_back('{wt: iw, got: 1'b0, rfm: irf, op: op,
                               alu: alu, rd: 32'h0, side: sd});
                if (iw) memq.push_back(fixed_rd ? 32'h80F1_7F02 : $urandom);
            end
        end
    endtask

    task automatic phase(input int n, input int pf, input int pv,
                         input int pr, input int pd, input bit fx);
        p_flush  = pf;
        p_valid  = pv;
        p_ready  = pr;
        p_dok    = pd;
        fixed_rd = fx;
        repeat (n) cycle();
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        do_reset();
        phase(300, 0, 90, 100, 0, 0);
        phase(500, 0, 80, 90, 60, 0);
        phase(400, 0, 90, 90, 100, 0);
        phase(500, 6, 70, 80, 50, 0);
        phase(400, 0, 80, 20, 40, 0);
        phase(400, 3, 80, 80, 60, 1);
        do_reset();
        phase(600, 15, 80, 70, 50, 0);
        phase(300, 2, 60, 90, 70, 0);
        do_reset();
        phase(200, 0, 50, 50, 50, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
